// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO read- and write-side control blocks.
// Gray converters operate on 32-bit values; callers size-cast to their pointer width.
package fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic int PTR_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended Gray input yields zero-extended binary, so narrow callers stay exact.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin = gray;
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync_write_to_read.sv
// Two-flop synchronizer carrying the Gray write pointer into the read clock domain.
module fifo_sync_write_to_read #(
    parameter int W = 5
) (
    input  logic         read_clock,
    input  logic         read_reset_n,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge read_clock or negedge read_reset_n) begin
        if (!read_reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/fifo_read_control.sv
// Read-side pointer, empty and underflow logic of the async FIFO (read clock domain only).
// Optional registered occupancy output is built when FIFO_READ_LEVEL_EN is defined.
module fifo_read_control
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = PTR_W(DEPTH)
) (
    input  logic          read_clock,
    input  logic          read_reset_n,
    input  logic          read_enable,
    input  logic [AW:0]   write_pointer,
    output logic [AW-1:0] read_address,
    output logic [AW:0]   read_pointer,
    output logic          empty,
    output logic          underflow,
    output logic [AW:0]   read_level
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_read_control: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic          r_empty;
    logic          r_underflow;

    logic [PW-1:0] w_wptr_s;
    logic          w_pop;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;

    fifo_sync_write_to_read #(
        .W (PW)
    ) u_sync_wptr (
        .read_clock   (read_clock),
        .read_reset_n (read_reset_n),
        .i_async      (write_pointer),
        .o_sync       (w_wptr_s)
    );

    assign w_pop       = read_enable & ~r_empty;
    assign w_bin_next  = r_bin + {{(PW-1){1'b0}}, w_pop};
    assign w_gray_next = PW'(bin2gray(32'(w_bin_next)));

    // Empty compares the post-pop pointer so the last pop closes the FIFO on the same edge.
    always_ff @(posedge read_clock or negedge read_reset_n) begin
        if (!read_reset_n) begin
            r_bin       <= '0;
            r_gray      <= '0;
            r_empty     <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_bin       <= w_bin_next;
            r_gray      <= w_gray_next;
            r_empty     <= (w_gray_next == w_wptr_s);
            r_underflow <= read_enable & r_empty;
        end
    end

    assign read_address = r_bin[AW-1:0];
    assign read_pointer = r_gray;
    assign empty        = r_empty;
    assign underflow    = r_underflow;

`ifdef FIFO_READ_LEVEL_EN
    logic [PW-1:0] r_level;
    logic [PW-1:0] w_wptr_bin;

    assign w_wptr_bin = PW'(gray2bin(32'(w_wptr_s)));

    always_ff @(posedge read_clock or negedge read_reset_n) begin
        if (!read_reset_n) begin
            r_level <= '0;
        end else begin
            r_level <= w_wptr_bin - w_bin_next;
        end
    end

    assign read_level = r_level;
`else
    assign read_level = '0;
`endif

endmodule

// File: tb/tb_fifo_read_control.sv
// Directed self-checking bench for fifo_read_control at DEPTH=16.
module tb_fifo_read_control;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic       re;
    logic [4:0] wp;
    logic [3:0] addr;
    logic [4:0] rp;
    logic       emp;
    logic       unf;
    logic [4:0] lvl;

    int n_checks = 0;
    int n_fail   = 0;
    int wbin     = 0;
    int rbin     = 0;
    logic [4:0] prev_rp;

    fifo_read_control #(.DEPTH(DEPTH)) dut (
        .read_clock    (clk),
        .read_reset_n  (rst_n),
        .read_enable   (re),
        .write_pointer (wp),
        .read_address  (addr),
        .read_pointer  (rp),
        .empty         (emp),
        .underflow     (unf),
        .read_level    (lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] g(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_level(input string tag, input int exp);
`ifdef FIFO_READ_LEVEL_EN
        chk(tag, 32'(lvl), 32'(exp));
`else
        chk(tag, 32'(lvl), 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        re    = 1'b0;
        wp    = '0;
        #12;
        chk("rst_empty", 32'(emp), 32'd1);
        chk("rst_underflow", 32'(unf), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_rptr", 32'(rp), 32'd0);
        chk("rst_level", 32'(lvl), 32'd0);
        rst_n = 1'b1;

        // Test 1: popping an empty FIFO
        re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_underflow", 32'(unf), 32'd1);
            chk("t1_empty", 32'(emp), 32'd1);
            chk("t1_addr", 32'(addr), 32'd0);
            chk("t1_rptr", 32'(rp), 32'd0);
        end
        re = 1'b0;

        // Test 2: single write then single pop
        wbin = 1;
        wp   = g(wbin);
        step();
        chk("t2_underflow_clr", 32'(unf), 32'd0);
        chk("t2_empty_e1", 32'(emp), 32'd1);
        step();
        chk("t2_empty_e2", 32'(emp), 32'd1);
        step();
        chk("t2_empty_e3", 32'(emp), 32'd0);
        chk_level("t2_level", 1);
        re = 1'b1;
        step();
        rbin = 1;
        chk("t2_addr", 32'(addr), 32'd1);
        chk("t2_rptr", 32'(rp), 32'b00001);
        chk("t2_empty_after_pop", 32'(emp), 32'd1);
        chk("t2_no_underflow", 32'(unf), 32'd0);
        re = 1'b0;

        // Test 3: 40 writes / 40 pops, pairs of writes followed by pairs of pops
        for (int i = 0; i < 20; i++) begin
            wbin++;
            wp = g(wbin);
            step();
            chk("t3_empty_pessimistic", 32'(emp), 32'd1);
            wbin++;
            wp = g(wbin);
            step();
            step();
            step();
            step();
            chk("t3_empty_filled", 32'(emp), 32'd0);
            re = 1'b1;
            for (int k = 0; k < 2; k++) begin
                prev_rp = rp;
                step();
                rbin++;
                chk("t3_addr", 32'(addr), 32'(rbin % 16));
                chk("t3_rptr", 32'(rp), 32'(g(rbin)));
                chk("t3_rptr_onebit", 32'($countones(rp ^ prev_rp)), 32'd1);
                chk("t3_empty", 32'(emp), (k == 1) ? 32'd1 : 32'd0);
                chk_level("t3_level", 1 - k);
                if (rbin % 16 == 0) chk("t3_wrap_addr", 32'(addr), 32'd0);
            end
            re = 1'b0;
        end

        // Test 4: async reset mid-burst at read_address 9
        chk("t4_pre_addr", 32'(addr), 32'd9);
        for (int i = 0; i < 3; i++) begin
            wbin++;
            wp = g(wbin);
            step();
        end
        step();
        step();
        step();
        chk("t4_pre_empty", 32'(emp), 32'd0);
        re = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_addr", 32'(addr), 32'd0);
        chk("t4_rst_rptr", 32'(rp), 32'd0);
        chk("t4_rst_empty", 32'(emp), 32'd1);
        chk("t4_rst_underflow", 32'(unf), 32'd0);
        chk("t4_rst_level", 32'(lvl), 32'd0);
        wp = '0;
        re = 1'b0;
        rbin = 0;
        #10;
        rst_n = 1'b1;
        step();
        chk("t4_release_empty", 32'(emp), 32'd1);
        chk("t4_release_addr", 32'(addr), 32'd0);

        // Test 5: full FIFO seen by the reader, then level tracking through pops
        wbin = 16;
        wp   = g(wbin);
        step();
        step();
        chk("t5_empty_e2", 32'(emp), 32'd1);
        chk_level("t5_level_e2", 0);
        step();
        chk("t5_empty_e3", 32'(emp), 32'd0);
        chk_level("t5_level_full", 16);
        re = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            rbin++;
            chk_level("t5_level_pop", 16 - k);
        end
        chk("t5_addr", 32'(addr), 32'd4);
        chk("t5_rptr", 32'(rp), 32'b00110);

        // Drain the remaining 12 entries
        for (int k = 1; k <= 12; k++) begin
            step();
            rbin++;
            chk("t5_drain_empty", 32'(emp), (k == 12) ? 32'd1 : 32'd0);
        end
        chk("t5_drain_addr", 32'(addr), 32'd0);
        chk("t5_drain_rptr", 32'(rp), 32'b11000);
        chk_level("t5_drain_level", 0);

        // Test 6: write lands and pop requested on the same edge
        wbin = 17;
        wp   = g(wbin);
        step();
        chk("t6_e1_empty", 32'(emp), 32'd1);
        chk("t6_e1_underflow", 32'(unf), 32'd1);
        chk("t6_e1_addr", 32'(addr), 32'd0);
        step();
        chk("t6_e2_empty", 32'(emp), 32'd1);
        chk("t6_e2_addr", 32'(addr), 32'd0);
        step();
        chk("t6_e3_empty", 32'(emp), 32'd0);
        chk("t6_e3_underflow", 32'(unf), 32'd1);
        chk_level("t6_e3_level", 1);
        step();
        chk("t6_pop_addr", 32'(addr), 32'd1);
        chk("t6_pop_empty", 32'(emp), 32'd1);
        chk("t6_pop_underflow", 32'(unf), 32'd0);
        chk("t6_pop_rptr", 32'(rp), 32'(g(17)));
        chk_level("t6_pop_level", 0);
        re = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
